// File: rtl/mips_pkg.sv
// Shared mini-MIPS definitions: datapath widths, fetch FSM encoding, FIFO entry layout.
package mips_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] word;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Ring-buffer index increment for depths that need not be a power of two.
   function automatic int unsigned ring_inc(input int unsigned idx, input int unsigned depth);
      return (idx + 32'd1 == depth) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {word, pc} FIFO with flush; head is registered storage, so a push is visible next cycle.
// No internal full protection: the fetch credit scheme never pushes into a full FIFO.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         empty,
   output logic [CW-1:0] occupancy
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_pop;

   assign empty  = (occupancy == '0);
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= PW'(ring_inc(32'(wr_ptr), DEPTH));
         end
         if (do_pop) rd_ptr <= PW'(ring_inc(32'(rd_ptr), DEPTH));
         if (push && !do_pop)      occupancy <= occupancy + CW'(1);
         else if (!push && do_pop) occupancy <= occupancy - CW'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited imem requests, redirect flush; response-to-decode latency is one cycle.
// Requests are withheld whenever in-flight plus buffered words would exceed DEPTH, so responses never stall.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_target;
   logic [CW-1:0]   outstanding, drop_cnt, occupancy;
   logic [CW-1:0]   inflight_nxt, drop_nxt;
   logic [CW:0]     credit_used;
   logic [XLEN-1:0] pc_q [DEPTH];
   logic [PW-1:0]   pcq_wr, pcq_rd;
   logic            fifo_empty, pop, req_hs, dropping, push;
   fetch_entry_t    push_data, head;

   assign redirect_target = redirect_pc & ~32'h3;

   assign instr_valid = !fifo_empty && (state != BOOT);
   assign pop         = instr_valid && instr_ready;
   assign instr       = head.word;
   assign instr_pc    = head.pc;

   // Every outstanding request already owns a FIFO slot; a pop this cycle frees one.
   assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
   assign imem_req_valid = (state == RUN) && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign dropping     = (drop_cnt != '0);
   assign push         = imem_rsp_valid && !dropping && !redirect_valid;
   assign push_data    = '{word: imem_rsp_data, pc: pc_q[pcq_rd]};
   assign inflight_nxt = outstanding - CW'(imem_rsp_valid) + CW'(req_hs);

   always_comb begin
      drop_nxt  = drop_cnt;
      state_nxt = state;
      if (redirect_valid) begin
         drop_nxt  = inflight_nxt;
         state_nxt = (inflight_nxt != '0) ? FLUSH : RUN;
      end else begin
         if (dropping && imem_rsp_valid) drop_nxt = drop_cnt - CW'(1);
         case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            FLUSH:   if (drop_nxt == '0) state_nxt = RUN;
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= inflight_nxt;
         drop_cnt    <= drop_nxt;
         if (redirect_valid) begin
            pc     <= redirect_target;
            pcq_wr <= '0;
            pcq_rd <= '0;
         end else begin
            if (req_hs) begin
               pc           <= pc + XLEN'(INSTR_BYTES);
               pc_q[pcq_wr] <= pc;
               pcq_wr       <= PW'(ring_inc(32'(pcq_wr), DEPTH));
            end
            if (push) pcq_rd <= PW'(ring_inc(32'(pcq_rd), DEPTH));
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .occupancy (occupancy)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against an in-order memory and a stream model.
module tb_instruction_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   typedef struct { logic [31:0] addr; logic [31:0] tag; int due; bit stale; } mreq_t;
   typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;

   mreq_t       memq[$];
   ent_t        bufq[$];
   int          cyc, last_due;
   int          lat_min, lat_max, p_mem_rdy, p_dec_rdy, p_redir, redir_cyc;
   logic [31:0] redir_tgt, next_req_pc;
   int          n_cmp = 0, n_bad = 0;
   logic [32:0] log_req [64];
   logic [32:0] log_pop [64];
   logic        log_vld [64];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // PC of the n-th instruction accepted by decode since the last reset.
   function automatic logic [32:0] nth_pop(input int n);
      int k = 0;
      for (int c = 0; c < 64; c++) begin
         if (log_pop[c][32]) begin
            if (k == n) return log_pop[c];
            k++;
         end
      end
      return 33'h0_DEAD_BEEF;
   endfunction

   function automatic int count_req(input int from, input int to);
      int k = 0;
      for (int c = from; c <= to; c++) if (log_req[c][32]) k++;
      return k;
   endfunction

   task automatic drive();
      imem_req_ready = ($urandom_range(99) < p_mem_rdy);
      instr_ready    = ($urandom_range(99) < p_dec_rdy);
      if (cyc == redir_cyc) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_tgt;
      end else if ($urandom_range(999) < p_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      end else begin
         redirect_valid = 1'b0;
         redirect_pc    = $urandom;
      end
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   // Check one cycle's outputs at the falling edge, advance the model, then drive the next cycle.
   task automatic step();
      mreq_t r;
      bit    pop, hs, exp_rv;
      int    stale, used, d;
      @(negedge clk);
      stale = 0;
      foreach (memq[i]) if (memq[i].stale) stale++;
      pop    = (bufq.size() > 0) && instr_ready;
      used   = memq.size() + bufq.size() - (pop ? 1 : 0);
      exp_rv = (cyc != 0) && !redirect_valid && (stale == 0) && (used < DEPTH);
      chk("req_valid", 33'(imem_req_valid), 33'(exp_rv));
      if (exp_rv) chk("req_addr", 33'(imem_req_addr), 33'(next_req_pc));
      chk("instr_valid", 33'(instr_valid), 33'(bufq.size() > 0));
      if (bufq.size() > 0) begin
         chk("instr", 33'(instr), 33'(bufq[0].word));
         chk("instr_pc", 33'(instr_pc), 33'(bufq[0].pc));
      end
      if (cyc < 64) begin
         log_vld[cyc] = instr_valid;
         log_req[cyc] = {imem_req_valid && imem_req_ready, imem_req_addr};
         log_pop[cyc] = {instr_valid && instr_ready && !redirect_valid, instr_pc};
      end
      hs = imem_req_valid && imem_req_ready;
      if (pop && !redirect_valid) void'(bufq.pop_front());
      if (imem_rsp_valid) begin
         r = memq.pop_front();
         if (!redirect_valid && !r.stale) bufq.push_back('{word: mem_word(r.addr), pc: r.tag});
      end
      if (hs) begin
         d        = cyc + $urandom_range(lat_max, lat_min);
         d        = (d > last_due) ? d : last_due + 1;
         last_due = d;
         memq.push_back('{addr: imem_req_addr, tag: next_req_pc, due: d, stale: 1'b0});
         next_req_pc = next_req_pc + 32'd4;
      end
      if (redirect_valid) begin
         bufq.delete();
         foreach (memq[i]) memq[i].stale = 1'b1;
         next_req_pc = redirect_pc & ~32'h3;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("rst req_valid", 33'(imem_req_valid), 33'd0);
      chk("rst req_addr", 33'(imem_req_addr), 33'(RESET_PC));
      chk("rst instr_valid", 33'(instr_valid), 33'd0);
      chk("rst instr", 33'(instr), 33'd0);
      chk("rst instr_pc", 33'(instr_pc), 33'd0);
      memq.delete();
      bufq.delete();
      last_due    = -1;
      next_req_pc = RESET_PC;
      for (int i = 0; i < 64; i++) begin
         log_req[i] = '0;
         log_pop[i] = '0;
         log_vld[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      drive();
   endtask

   task automatic knobs(input int lmin, input int lmax, input int pm, input int pd, input int pr,
                        input int rc, input logic [31:0] rt);
      lat_min = lmin; lat_max = lmax; p_mem_rdy = pm; p_dec_rdy = pd; p_redir = pr;
      redir_cyc = rc; redir_tgt = rt;
   endtask

   initial begin
      imem_req_ready = 1'b0; instr_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; cyc = 0;

      // Streaming at L=1: requests from cycle 1, first delivery in cycle 3, then one per cycle.
      knobs(1, 1, 100, 100, 0, -1, 32'h0);
      do_reset();
      repeat (14) step();
      chk("s1 req c1", log_req[1], {1'b1, 32'h0});
      chk("s1 req c2", log_req[2], {1'b1, 32'h4});
      chk("s1 req c3", log_req[3], {1'b1, 32'h8});
      chk("s1 vld c2", 33'(log_vld[2]), 33'd0);
      chk("s1 pop c3", log_pop[3], {1'b1, 32'h0});
      chk("s1 pop c4", log_pop[4], {1'b1, 32'h4});
      begin
         int k = 0;
         for (int c = 3; c <= 12; c++) if (log_pop[c][32]) k++;
         chk("s1 throughput", 33'(k), 33'd10);
      end

      // Decode stalled: only DEPTH requests go out, then in-order delivery resumes.
      knobs(1, 1, 100, 0, 0, -1, 32'h0);
      do_reset();
      repeat (5) step();
      instr_ready = 1'b1;
      p_dec_rdy   = 100;
      repeat (10) step();
      chk("s2 reqs while stalled", 33'(count_req(0, 4)), 33'd2);
      chk("s2 first pop", nth_pop(0), {1'b1, 32'h0});
      chk("s2 second pop", nth_pop(1), {1'b1, 32'h4});
      chk("s2 third pop", nth_pop(2), {1'b1, 32'h8});

      // L=3, redirect with two requests in flight.
      knobs(3, 3, 100, 100, 0, 3, 32'h0000_0103);
      do_reset();
      repeat (16) step();
      chk("s3 no req c3-5", 33'(count_req(3, 5)), 33'd0);
      chk("s3 req c6", log_req[6], {1'b1, 32'h100});
      chk("s3 first pop", nth_pop(0), {1'b1, 32'h100});
      chk("s3 pop c10", log_pop[10], {1'b1, 32'h100});

      // Address wrap at the top of the space.
      knobs(1, 1, 100, 100, 0, 1, 32'hFFFF_FFF8);
      do_reset();
      repeat (10) step();
      chk("s4 req c2", log_req[2], {1'b1, 32'hFFFF_FFF8});
      chk("s4 req c3", log_req[3], {1'b1, 32'hFFFF_FFFC});
      chk("s4 req c4", log_req[4], {1'b1, 32'h0000_0000});
      chk("s4 pop 2", nth_pop(2), {1'b1, 32'h0000_0000});

      // Redirect colliding with a decode handshake and a memory response.
      knobs(1, 1, 100, 100, 0, 3, 32'h0000_0200);
      do_reset();
      repeat (10) step();
      chk("s5 no req c3", 33'(log_req[3][32]), 33'd0);
      chk("s5 empty c4", 33'(log_vld[4]), 33'd0);
      chk("s5 req c4", log_req[4], {1'b1, 32'h200});
      chk("s5 first pop", nth_pop(0), {1'b1, 32'h200});

      // Reset while the FIFO is full, then a clean restart.
      knobs(1, 1, 100, 0, 0, -1, 32'h0);
      do_reset();
      repeat (8) step();
      @(negedge clk);
      chk("s6 full valid", 33'(instr_valid), 33'd1);
      chk("s6 full no req", 33'(imem_req_valid), 33'd0);
      p_dec_rdy = 100;
      do_reset();
      repeat (6) step();
      chk("s6 restart req", log_req[1], {1'b1, RESET_PC});

      // Randomized traffic; each new reset lands mid-stream.
      for (int k = 0; k < 8; k++) begin
         knobs(1, $urandom_range(5, 1), $urandom_range(100, 50), $urandom_range(100, 30),
               $urandom_range(60), -1, 32'h0);
         do_reset();
         repeat (400) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
